// File: rtl/spi_cfg_if.sv
// Purpose : bundles the two requester command channels, the status strobes and the SPI pins of spi_cfg_master.
// Latency : none; wires only.
// Backpressure: reqN_ready from the master side qualifies each reqN_valid command.
// Ports   : req0_*/req1_* (valid, ready, addr, data) command channels; busy, done, done_id, err status; SCLK, nCS, COPI pins.
// Modports: master = the serializer (spi_cfg_master); slave = the requester/observer side.
interface spi_cfg_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              busy;
    logic              done;
    logic              done_id;
    logic              err;
    logic              SCLK;
    logic              nCS;
    logic              COPI;

    modport master (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output busy, done, done_id, err,
        output SCLK, nCS, COPI
    );

    modport slave (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  busy, done, done_id, err,
        input  SCLK, nCS, COPI
    );
endinterface

// File: rtl/spi_cfg_master.sv
// Purpose : round-robin arbiter over two write requesters + mode-0 SPI serializer of 16-bit {1'b1, addr, data} frames.
// Latency : nCS falls on the handshake edge; frame lasts CLK_DIV*33 clk, then NCS_GAP clk of gap before the next grant.
// Backpressure: reqN_ready is high only in IDLE for the granted requester; commands wait (valid held) while a frame is in flight.
// Ports   : clk, rst_n (synchronous, active low); bus (spi_cfg_if.master): req0/req1 valid/ready/addr/data,
//           busy, done, done_id, err, SCLK, nCS, COPI (all SPI pins and done/err registered).
// Option  : define SPI_CFG_ADDR_CHK_EN to reject (handshake, no frame, err pulse) commands with addr > MAX_ADDR.
module spi_cfg_master #(
    parameter int CLK_DIV  = 4,
    parameter int NCS_GAP  = 4,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int MAX_ADDR = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    spi_cfg_if.master  bus
);
    // Frame layout is {write flag, addr, data}; ADDR_W + DATA_W + 1 is expected to be 16.
    localparam int FRAME_W = ADDR_W + DATA_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(NCS_GAP - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_W - 1);

    logic [2:0]         state;
    logic [7:0]         tick_cnt;
    logic [3:0]         bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic               frame_id;
    logic               rr_ptr;
    logic               sclk_q;
    logic               ncs_q;
    logic               copi_q;
    logic               done_q;
    logic               done_id_q;
    logic               err_q;

    logic               any_vld;
    logic               grant;
    logic               hs;
    logic               tick_last;
    logic               addr_bad;
    logic [ADDR_W-1:0]  gnt_addr;
    logic [DATA_W-1:0]  gnt_data;

    // Arbitration: a lone valid requester wins; on contention the rr pointer decides.
    always_comb begin
        any_vld = bus.req0_valid | bus.req1_valid;
        grant   = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            grant = rr_ptr;
        else
            grant = bus.req1_valid;
        gnt_addr = grant ? bus.req1_addr : bus.req0_addr;
        gnt_data = grant ? bus.req1_data : bus.req0_data;
    end

    // any_vld guarantees the granted requester is the valid one, so hs is the handshake.
    assign hs             = (state == S_IDLE) && any_vld;
    assign bus.req0_ready = hs && !grant;
    assign bus.req1_ready = hs && grant;
    assign tick_last      = (tick_cnt == DIV_LAST);

`ifdef SPI_CFG_ADDR_CHK_EN
    assign addr_bad = (gnt_addr > ADDR_W'(MAX_ADDR));
`else
    assign addr_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tick_cnt  <= 8'd0;
            bit_cnt   <= 4'd0;
            shreg     <= '0;
            frame_id  <= 1'b0;
            rr_ptr    <= 1'b0;
            sclk_q    <= 1'b0;
            ncs_q     <= 1'b1;
            copi_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        // Pointer advances even for a rejected command so a bad requester cannot hog the grant.
                        rr_ptr <= ~grant;
                        if (addr_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            state    <= S_SETUP;
                            shreg    <= {1'b1, gnt_addr, gnt_data};
                            frame_id <= grant;
                            ncs_q    <= 1'b0;
                            copi_q   <= 1'b1;
                            tick_cnt <= 8'd0;
                        end
                    end
                end
                S_SETUP: begin
                    if (tick_last) begin
                        state    <= S_HI;
                        sclk_q   <= 1'b1;
                        bit_cnt  <= 4'd0;
                        tick_cnt <= 8'd0;
                    end else begin
                        tick_cnt <= tick_cnt + 8'd1;
                    end
                end
                S_HI: begin
                    if (tick_last) begin
                        // Falling SCLK and the next COPI bit leave on the same edge; target sampled on the rise.
                        state    <= S_LO;
                        sclk_q   <= 1'b0;
                        shreg    <= shreg << 1;
                        copi_q   <= shreg[FRAME_W-2];
                        tick_cnt <= 8'd0;
                    end else begin
                        tick_cnt <= tick_cnt + 8'd1;
                    end
                end
                S_LO: begin
                    if (tick_last) begin
                        tick_cnt <= 8'd0;
                        if (bit_cnt == BIT_LAST) begin
                            // Last LO was the hold phase after bit 0.
                            state     <= S_GAP;
                            ncs_q     <= 1'b1;
                            copi_q    <= 1'b0;
                            done_q    <= 1'b1;
                            done_id_q <= frame_id;
                        end else begin
                            state   <= S_HI;
                            sclk_q  <= 1'b1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    if (tick_cnt == GAP_LAST) begin
                        state    <= S_IDLE;
                        tick_cnt <= 8'd0;
                    end else begin
                        tick_cnt <= tick_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    tick_cnt <= 8'd0;
                    sclk_q   <= 1'b0;
                    ncs_q    <= 1'b1;
                    copi_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.err     = err_q;
    assign bus.SCLK    = sclk_q;
    assign bus.nCS     = ncs_q;
    assign bus.COPI    = copi_q;
endmodule

// File: tb/tb_spi_cfg_master.sv
// Purpose : directed self-checking bench for spi_cfg_master (CLK_DIV=4/NCS_GAP=4 instance and a 2/1 boundary instance).
// Latency : n/a.
// Backpressure: requesters hold valid until ready is seen, then drop valid and scramble addr/data.
module tb_spi_cfg_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   mon_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    spi_cfg_if #(.ADDR_W(7), .DATA_W(8)) ba ();
    spi_cfg_if #(.ADDR_W(7), .DATA_W(8)) bb ();

    spi_cfg_master #(.CLK_DIV(4), .NCS_GAP(4), .ADDR_W(7), .DATA_W(8), .MAX_ADDR(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ba));
    spi_cfg_master #(.CLK_DIV(2), .NCS_GAP(1), .ADDR_W(7), .DATA_W(8), .MAX_ADDR(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bb));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- observer for instance A ----------------
    logic        a_prev_sclk = 1'b0, a_prev_ncs = 1'b1;
    logic [15:0] a_bits = '0;
    int          a_edges = 0, a_low = 0, a_high_run = 0;
    logic [15:0] a_frame_q[$];
    int          a_edges_q[$], a_low_q[$], a_hs_q[$], a_done_id_q[$];
    int          a_done_cnt = 0, a_err_cnt = 0, a_falls = 0, a_busy_viol = 0;
    int          a_rdy0_cnt = 0, a_rdy1_cnt = 0, a_gap_min = 100000;

    always @(negedge clk) if (mon_en) begin
        if (ba.SCLK && !a_prev_sclk) begin
            a_bits = {a_bits[14:0], ba.COPI};
            a_edges++;
        end
        if (ba.nCS) begin
            if (!a_prev_ncs) begin
                a_frame_q.push_back(a_bits);
                a_edges_q.push_back(a_edges);
                a_low_q.push_back(a_low);
                a_bits = '0; a_edges = 0; a_low = 0; a_high_run = 0;
            end
            a_high_run++;
        end else begin
            if (a_prev_ncs) begin
                a_falls++;
                if (a_frame_q.size() > 0 && a_high_run < a_gap_min) a_gap_min = a_high_run;
            end
            a_low++;
            if (!ba.busy) a_busy_viol++;
        end
        if (ba.req0_ready) a_rdy0_cnt++;
        if (ba.req1_ready) a_rdy1_cnt++;
        if (ba.req0_valid && ba.req0_ready) a_hs_q.push_back(0);
        if (ba.req1_valid && ba.req1_ready) a_hs_q.push_back(1);
        if (ba.done) begin a_done_cnt++; a_done_id_q.push_back(int'(ba.done_id)); end
        if (ba.err) a_err_cnt++;
        a_prev_sclk = ba.SCLK;
        a_prev_ncs  = ba.nCS;
    end

    // ---------------- observer for instance B ----------------
    logic        b_prev_sclk = 1'b0, b_prev_ncs = 1'b1;
    logic [15:0] b_bits = '0, b_last_frame = '0;
    int          b_edges = 0, b_last_edges = 0, b_low = 0, b_last_low = 0, b_done_cnt = 0;
    int          b_hi_run = 0, b_lo_run = 0;
    int          b_hi_min = 1000, b_hi_max = 0, b_lo_min = 1000, b_lo_max = 0;

    always @(negedge clk) if (mon_en) begin
        if (bb.SCLK) begin
            b_hi_run++;
        end else if (b_prev_sclk) begin
            if (b_hi_run < b_hi_min) b_hi_min = b_hi_run;
            if (b_hi_run > b_hi_max) b_hi_max = b_hi_run;
            b_hi_run = 0;
        end
        if (!bb.nCS) begin
            b_low++;
            if (!bb.SCLK) begin
                b_lo_run++;
            end else if (!b_prev_sclk) begin
                if (b_lo_run < b_lo_min) b_lo_min = b_lo_run;
                if (b_lo_run > b_lo_max) b_lo_max = b_lo_run;
                b_lo_run = 0;
                b_bits = {b_bits[14:0], bb.COPI};
                b_edges++;
            end
        end else if (!b_prev_ncs) begin
            if (b_lo_run < b_lo_min) b_lo_min = b_lo_run;
            if (b_lo_run > b_lo_max) b_lo_max = b_lo_run;
            b_lo_run = 0;
            b_last_frame = b_bits; b_last_edges = b_edges; b_last_low = b_low;
            b_bits = '0; b_edges = 0; b_low = 0;
        end
        if (bb.done) b_done_cnt++;
        b_prev_sclk = bb.SCLK;
        b_prev_ncs  = bb.nCS;
    end

    // Drive one command and hold it until the handshake edge has passed.
    task automatic send(input bit on_b, input bit id, input logic [6:0] addr, input logic [7:0] data);
        logic got;
        got = 1'b0;
        @(negedge clk);
        if (!on_b && !id) begin ba.req0_valid = 1'b1; ba.req0_addr = addr; ba.req0_data = data; end
        if (!on_b &&  id) begin ba.req1_valid = 1'b1; ba.req1_addr = addr; ba.req1_data = data; end
        if ( on_b)        begin bb.req0_valid = 1'b1; bb.req0_addr = addr; bb.req0_data = data; end
        for (int i = 0; i < 3000; i++) begin
            #1;
            got = on_b ? bb.req0_ready : (id ? ba.req1_ready : ba.req0_ready);
            @(posedge clk); #1;
            if (got) break;
            @(negedge clk);
        end
        check("handshake_seen", 32'(got), 32'd1);
        if (!on_b && !id) begin ba.req0_valid = 1'b0; ba.req0_addr = ~addr; ba.req0_data = ~data; end
        if (!on_b &&  id) begin ba.req1_valid = 1'b0; ba.req1_addr = ~addr; ba.req1_data = ~data; end
        if ( on_b)        begin bb.req0_valid = 1'b0; bb.req0_addr = ~addr; bb.req0_data = ~data; end
    endtask

    task automatic wait_done_a(input int target);
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk); #1;
            if (a_done_cnt >= target && !ba.busy) break;
        end
    endtask

    int base, dbase, fbase, ebase;

    initial begin
        ba.req0_valid = 0; ba.req0_addr = '0; ba.req0_data = '0;
        ba.req1_valid = 0; ba.req1_addr = '0; ba.req1_data = '0;
        bb.req0_valid = 0; bb.req0_addr = '0; bb.req0_data = '0;
        bb.req1_valid = 0; bb.req1_addr = '0; bb.req1_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); mon_en = 1'b1; rst_n = 1'b1;
        @(negedge clk); #1;

        // Reset state
        check("rst_sclk", 32'(ba.SCLK), 32'd0);
        check("rst_ncs", 32'(ba.nCS), 32'd1);
        check("rst_copi", 32'(ba.COPI), 32'd0);
        check("rst_busy", 32'(ba.busy), 32'd0);
        check("rst_done", 32'(ba.done), 32'd0);
        check("rst_done_id", 32'(ba.done_id), 32'd0);
        check("rst_err", 32'(ba.err), 32'd0);
        check("rst_rdy", {30'd0, ba.req1_ready, ba.req0_ready}, 32'd0);

        // Contention: both valid continuously, pointer starts at 0
        @(negedge clk);
        ba.req0_valid = 1; ba.req0_addr = 7'h01; ba.req0_data = 8'h5A;
        ba.req1_valid = 1; ba.req1_addr = 7'h03; ba.req1_data = 8'hC3;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (a_hs_q.size() >= 4) break;
        end
        ba.req0_valid = 0; ba.req1_valid = 0;
        wait_done_a(4);
        check("cont_hs_cnt", 32'(a_hs_q.size()), 32'd4);
        check("cont_done_cnt", 32'(a_done_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("cont_grant", 32'(a_hs_q[i]), 32'(i % 2));
            check("cont_done_id", 32'(a_done_id_q[i]), 32'(i % 2));
            check("cont_frame", 32'(a_frame_q[i]), (i % 2) ? 32'h83C3 : 32'h815A);
        end
        check("cont_rdy0_cnt", 32'(a_rdy0_cnt), 32'd2);
        check("cont_rdy1_cnt", 32'(a_rdy1_cnt), 32'd2);
        check("cont_gap_ge", 32'(a_gap_min >= 4), 32'd1);
        check("cont_gap_exact", 32'(a_gap_min), 32'd5);

        // Single write addr=0x02 data=0xA5 from req0
        dbase = a_done_cnt;
        send(1'b0, 1'b0, 7'h02, 8'hA5);
        wait_done_a(dbase + 1);
        check("w1_done_cnt", 32'(a_done_cnt), 32'(dbase + 1));
        check("w1_frame", 32'(a_frame_q[$]), 32'h82A5);
        check("w1_edges", 32'(a_edges_q[$]), 32'd16);
        check("w1_ncs_low", 32'(a_low_q[$]), 32'd132);
        check("w1_done_id", 32'(a_done_id_q[$]), 32'd0);
        check("w1_busy_viol", 32'(a_busy_viol), 32'd0);

        // Fairness: req1 alone three times, then both valid -> req0 first
        for (int k = 0; k < 3; k++) send(1'b0, 1'b1, 7'(k), 8'(8'h10 + k));
        wait_done_a(dbase + 4);
        base = a_hs_q.size();
        @(negedge clk);
        ba.req0_valid = 1; ba.req0_addr = 7'h04; ba.req0_data = 8'h01;
        ba.req1_valid = 1; ba.req1_addr = 7'h04; ba.req1_data = 8'h02;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (a_hs_q.size() >= base + 1) break;
        end
        ba.req0_valid = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (a_hs_q.size() >= base + 2) break;
        end
        ba.req1_valid = 0;
        check("fair_hs_cnt", 32'(a_hs_q.size()), 32'(base + 2));
        check("fair_first", 32'(a_hs_q[base]), 32'd0);
        check("fair_second", 32'(a_hs_q[base + 1]), 32'd1);
        wait_done_a(dbase + 6);

        // Reset mid-frame after the 5th SCLK rise
        dbase = a_done_cnt;
        send(1'b0, 1'b0, 7'h03, 8'h77);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (a_edges >= 5) break;
        end
        check("rst_mid_edges", 32'(a_edges), 32'd5);
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("rst_mid_ncs", 32'(ba.nCS), 32'd1);
        check("rst_mid_sclk", 32'(ba.SCLK), 32'd0);
        check("rst_mid_copi", 32'(ba.COPI), 32'd0);
        check("rst_mid_busy", 32'(ba.busy), 32'd0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("rst_mid_no_done", 32'(a_done_cnt), 32'(dbase));
        send(1'b0, 1'b1, 7'h00, 8'h01);
        wait_done_a(dbase + 1);
        check("rst_new_frame", 32'(a_frame_q[$]), 32'h8001);
        check("rst_new_edges", 32'(a_edges_q[$]), 32'd16);
        check("rst_new_low", 32'(a_low_q[$]), 32'd132);
        check("rst_new_done_id", 32'(a_done_id_q[$]), 32'd1);

        // Boundary instance CLK_DIV=2, NCS_GAP=1
        send(1'b1, 1'b0, 7'h01, 8'hFF);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (b_done_cnt >= 1 && !bb.busy) break;
        end
        check("b_done_cnt", 32'(b_done_cnt), 32'd1);
        check("b_frame", 32'(b_last_frame), 32'h81FF);
        check("b_edges", 32'(b_last_edges), 32'd16);
        check("b_ncs_low", 32'(b_last_low), 32'd66);
        check("b_hi_min", 32'(b_hi_min), 32'd2);
        check("b_hi_max", 32'(b_hi_max), 32'd2);
        check("b_lo_min", 32'(b_lo_min), 32'd2);
        check("b_lo_max", 32'(b_lo_max), 32'd2);

        // Out-of-range address 0x05
        dbase = a_done_cnt; fbase = a_falls; ebase = a_err_cnt;
        send(1'b0, 1'b0, 7'h05, 8'h11);
`ifdef SPI_CFG_ADDR_CHK_EN
        repeat (20) @(negedge clk);
        #1;
        check("chk_err_pulse", 32'(a_err_cnt), 32'(ebase + 1));
        check("chk_no_ncs", 32'(a_falls), 32'(fbase));
        check("chk_no_done", 32'(a_done_cnt), 32'(dbase));
        send(1'b0, 1'b0, 7'h04, 8'h3C);
        wait_done_a(dbase + 1);
        check("chk_ok_frame", 32'(a_frame_q[$]), 32'h843C);
        check("chk_ok_low", 32'(a_low_q[$]), 32'd132);
`else
        wait_done_a(dbase + 1);
        check("nochk_err", 32'(a_err_cnt), 32'(ebase));
        check("nochk_frame", 32'(a_frame_q[$]), 32'h8511);
        check("nochk_falls", 32'(a_falls), 32'(fbase + 1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_cfg_master.md
Name: spi_cfg_master

Overview:
- Round-robin arbiter and SPI write-frame serializer that configures the on-chip SPI register peripheral (registers 0x00-0x04).
- Two on-chip requesters submit (address, data) write commands over valid/ready.
- The block grants one requester at a time and drives SCLK/nCS/COPI with one 16-bit write frame per command.
- SPI mode 0: SCLK idles low, COPI changes while SCLK is low, the target samples on the SCLK rising edge, MSB first.

Parameters:
- CLK_DIV, 4, SCLK half-period in clk cycles. Legal range 2..255.
- NCS_GAP, 4, clk cycles nCS is held high after a frame before the next grant. Legal range 1..255.
- ADDR_W, 7, address field width.
- DATA_W, 8, data field width.
- MAX_ADDR, 4, highest valid register address. Used only by the optional feature.

Ports:
- clk input 1: system clock.
- rst_n input 1: synchronous, active-low reset, sampled on the clk rising edge.
- req0_valid input 1: requester 0 has a command.
- req0_ready output 1: requester 0 command accepted this cycle.
- req0_addr input ADDR_W: requester 0 register address.
- req0_data input DATA_W: requester 0 write data.
- req1_valid, req1_ready, req1_addr, req1_data: same as requester 0, for requester 1.
- busy output 1: high whenever state != IDLE.
- done output 1: one-cycle pulse at the end of each frame.
- done_id output 1: requester index of the frame that just finished. Valid only while done=1.
- err output 1: one-cycle pulse when a command is rejected (optional feature). Tied 0 when the feature is compiled out.
- SCLK output 1: SPI clock.
- nCS output 1: SPI chip select, active low.
- COPI output 1: SPI data out.

Behaviour:
- Reset values: SCLK=0, nCS=1, COPI=0, busy=0, done=0, done_id=0, err=0, both ready=0, rr pointer=0 (requester 0 preferred).
  - Reset asserted mid-frame aborts the frame: nCS goes high and SCLK low on the next clk edge.
  - The partial frame is not retried and no done pulse is issued.
- Arbitration:
  - Happens only in IDLE. reqN_ready is combinational: (state==IDLE) and grant==N.
  - If only one requester is valid, it is granted.
  - If both are valid, the rr pointer's requester is granted.
  - On a handshake (valid & ready) the pointer moves to the other requester.
  - At most one ready is high in any cycle.
  - When neither requester is valid, no grant is made and the pointer is unchanged.
- On handshake, the frame shift register latches {1'b1, addr, data} (16 bits; bit 15 is the write flag) along with the granted index. The state goes to SETUP.
- FSM states and transitions:
  - IDLE: waits for a handshake.
  - SETUP:
    - nCS=0, SCLK=0, COPI=frame[15].
    - Lasts CLK_DIV cycles, then goes to HI.
  - HI:
    - SCLK=1 for CLK_DIV cycles; COPI is held stable.
    - Bit counter counts 0..15.
    - Goes to LO.
  - LO:
    - SCLK=0 for CLK_DIV cycles.
    - On LO entry the frame shifts left by 1 and COPI shows the next bit.
    - After the 16th LO (the hold phase): nCS goes high, done=1 and done_id is driven for one cycle, then the state goes to GAP.
    - Otherwise the state goes back to HI.
  - GAP: nCS=1, SCLK=0, COPI=0 for NCS_GAP cycles, then goes to IDLE.
- Timing:
  - nCS low time is exactly CLK_DIV*33 cycles.
  - There are exactly 16 SCLK rising edges per frame.
  - A back-to-back frame starts no sooner than NCS_GAP+1 cycles after nCS rises, counting the IDLE handshake cycle.
  - Throughput is one frame per CLK_DIV*33+NCS_GAP+1 cycles.
- Requester inputs are ignored after the handshake, so addr/data may change freely.
- Widths: ADDR_W+DATA_W+1 must equal 16.
- The half-period counter is 8 bits. The divide is exact and produces no glitch on SCLK.
- All SPI outputs are registered.

Optional Feature:
- Macro: SPI_CFG_ADDR_CHK_EN.
- Defined:
  - A command with addr > MAX_ADDR is still handshaked (ready=1) and the rr pointer still advances.
  - No frame is sent: nCS stays high.
  - err pulses for one cycle on the cycle after the handshake.
  - The state returns to IDLE.
- Undefined: every command is transmitted regardless of address, and err is constant 0.

Test Plan:
- Single write, CLK_DIV=4:
  - Stimulus: req0 sends addr=0x02, data=0xA5.
  - Required: COPI samples on the 16 SCLK rising edges = 1,0000010,10100101; nCS low exactly 132 cycles; done=1 with done_id=0 once; busy high throughout.
- Contention:
  - Stimulus: req0 and req1 both valid continuously with distinct commands.
  - Required: grants alternate 0,1,0,1; each ready pulses exactly once per frame; the gap between frames is nCS high for ≥ NCS_GAP cycles.
- Idle-valid fairness:
  - Stimulus: req1 alone sends 3 commands, then req0 and req1 become valid together.
  - Required: req0 is granted first, because the pointer moved past 1.
- Reset mid-frame:
  - Stimulus: rst_n=0 for 1 cycle after the 5th SCLK rising edge.
  - Required: next cycle nCS=1, SCLK=0, COPI=0, no done pulse; a new command afterwards produces a clean full frame.
- CLK_DIV=2, NCS_GAP=1 boundary:
  - Stimulus: one write.
  - Required: SCLK high and low phases are exactly 2 cycles each; nCS low 66 cycles.
- With SPI_CFG_ADDR_CHK_EN:
  - Stimulus: req0 sends addr=0x05.
  - Required: ready=1, err pulse, nCS never falls; a following addr=0x04 write is transmitted normally.
